// File: rtl/boot_request_pkg.sv
// Shared types and constants for the boot request block: FSM state encoding,
// default timing parameters, flash address width and the slot-to-address helper.
package boot_request_pkg;

  localparam int ADDR_W                  = 24;
  localparam int DEF_DEBOUNCE_CYCLES     = 65536;
  localparam int DEF_HOLD_CYCLES         = 1024;
  localparam int DEF_LOCK_CYCLES         = 32;
  localparam int DEF_SLOT_SHIFT          = 19;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    FIRE = 2'd2,
    LOCK = 2'd3
  } state_t;

  // Flash start address of a slot: zero-extended slot number shifted by the
  // slot size, with anything above the 24-bit address space dropped.
  function automatic logic [ADDR_W-1:0] slot_addr(input logic [3:0] target, input int shift);
    logic [ADDR_W-1:0] base;
    base = ADDR_W'(target);
    return base << shift;
  endfunction

endpackage

// File: rtl/boot_request_debounce.sv
// Two-flop synchronizer followed by a counting debouncer for the active-low
// boot button. Emits the accepted (stable) level and a one-cycle press pulse
// on each accepted high-to-low transition.
module debounce
  import boot_request_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic clock,
  input  logic reset,
  input  logic button,
  output logic stable,
  output logic press
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             meta;
  logic             sync;
  logic [CNT_W-1:0] count;

  // Bring the asynchronous button into the clock domain; idle level is released (1).
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      meta <= 1'b1;
      sync <= 1'b1;
    end else begin
      meta <= button;
      sync <= meta;
    end
  end

  // Accept a new level only after it has been seen on DEBOUNCE_CYCLES consecutive samples.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      stable <= 1'b1;
      count  <= '0;
      press  <= 1'b0;
    end else begin
      press <= 1'b0;
      if (sync == stable) begin
        count <= '0;
      end else if (count == LAST) begin
        stable <= sync;
        count  <= '0;
        press  <= ~sync;
      end else begin
        count <= count + 1'b1;
      end
    end
  end

endmodule

// File: rtl/boot_request.sv
// Boot request controller: turns a debounced button press (golden slot 0) or a
// software go strobe (selected slot) into a frozen flash address, a fixed hold
// period, a single registered reboot pulse and a lockout window.
module boot_request
  import boot_request_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int HOLD_CYCLES     = DEF_HOLD_CYCLES,
  parameter int LOCK_CYCLES     = DEF_LOCK_CYCLES,
  parameter int SLOT_SHIFT      = DEF_SLOT_SHIFT
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              button,
  input  logic              sel_we,
  input  logic [3:0]        sel_d,
  input  logic              go,
  output logic [3:0]        slot,
  output logic              busy,
  output logic [ADDR_W-1:0] spi_addr,
  output logic              reboot
);

  localparam int CNT_MAX = (HOLD_CYCLES > LOCK_CYCLES) ? HOLD_CYCLES : LOCK_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX) + 1;
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(LOCK_CYCLES - 1);

  state_t           state;
  logic [CNT_W-1:0] count;
  logic             button_level;
  logic             press;
  logic             press_evt;

  debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debounce (
    .clock (clock),
    .reset (reset),
    .button(button),
    .stable(button_level),
    .press (press)
  );

  // The press pulse is issued together with the stable level going low; requiring
  // both means a pulse can never be honoured against a released button.
  assign press_evt = press & ~button_level;

  // Request FSM; every output is a register so reboot and busy are glitch-free.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      count    <= '0;
      slot     <= 4'd0;
      spi_addr <= '0;
      reboot   <= 1'b0;
      busy     <= 1'b0;
    end else begin
      reboot <= 1'b0;
      case (state)
        IDLE: begin
          if (sel_we) begin
            slot <= sel_d;
          end
          // A button press always requests the golden image and beats go.
          if (press_evt) begin
            spi_addr <= slot_addr(4'd0, SLOT_SHIFT);
            state    <= ARM;
            busy     <= 1'b1;
            count    <= '0;
          end else if (go) begin
            // A slot written in the same cycle as go is the one that gets booted.
            spi_addr <= slot_addr(sel_we ? sel_d : slot, SLOT_SHIFT);
            state    <= ARM;
            busy     <= 1'b1;
            count    <= '0;
          end
        end
        ARM: begin
          if (count == HOLD_LAST) begin
            state  <= FIRE;
            reboot <= 1'b1;
            count  <= '0;
          end else begin
            count <= count + 1'b1;
          end
        end
        FIRE: begin
          state <= LOCK;
          count <= '0;
        end
        LOCK: begin
          if (count == LOCK_LAST) begin
            state <= IDLE;
            busy  <= 1'b0;
            count <= '0;
          end else begin
            count <= count + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          count <= '0;
        end
      endcase
    end
  end

endmodule

// File: doc/boot_request.md
BOOT_REQUEST -- requirements
Module: boot_request

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 65536, the number of stable samples required to accept a button level change.
REQ-002 SHALL have parameter HOLD_CYCLES, default 1024, the number of cycles spi_addr is held frozen before the reboot pulse.
REQ-003 SHALL have parameter LOCK_CYCLES, default 32, the number of cycles the block ignores requests after a pulse.
REQ-004 SHALL have parameter SLOT_SHIFT, default 19, the log2 of the slot size in bytes; SLOT_SHIFT+4 <= 24.
REQ-005 SHALL have port clock, input, 1 bit: the single clock, 20 MHz maximum.
REQ-006 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-007 SHALL have port button, input, 1 bit: raw boot button, active-low, asynchronous to clock.
REQ-008 SHALL have port sel_we, input, 1 bit: slot register write strobe, one cycle.
REQ-009 SHALL have port sel_d, input, 4 bits: slot number written on sel_we.
REQ-010 SHALL have port go, input, 1 bit: software reboot request, one-cycle strobe.
REQ-011 SHALL have port slot, output, 4 bits: the currently latched slot register.
REQ-012 SHALL have port busy, output, 1 bit: high in any state other than IDLE.
REQ-013 SHALL have port spi_addr, output, 24 bits: flash start address for the reconfiguration stage.
REQ-014 SHALL have port reboot, output, 1 bit: one-cycle reboot pulse to the reconfiguration stage.

Function
REQ-015 SHALL pass button through a 2-FF synchronizer, then a debouncer: the counter clears whenever the synchronized level equals the stable level; the stable level updates when the counter reaches DEBOUNCE_CYCLES-1.
REQ-016 SHALL raise a press event for exactly one cycle on a stable-level 1->0 transition; a release SHALL raise no event.
REQ-017 SHALL load the slot register from sel_d on sel_we only while IDLE; sel_we SHALL be ignored while busy.
REQ-018 SHALL implement an FSM with states IDLE, ARM, FIRE and LOCK.
REQ-019 In IDLE, a press event SHALL load target=0 and go to ARM; go SHALL load target=slot and go to ARM.
REQ-020 When a press event and go occur in the same cycle, the press SHALL win (target=0).
REQ-021 When sel_we and go occur in the same cycle in IDLE, go SHALL use the newly written sel_d as target.
REQ-022 On entry to ARM, spi_addr SHALL be set to zero-extended target<<SLOT_SHIFT, truncated to 24 bits, and SHALL stay constant until the next ARM entry.
REQ-023 ARM SHALL last exactly HOLD_CYCLES cycles, then go to FIRE.
REQ-024 FIRE SHALL assert reboot for exactly one cycle, then go to LOCK.
REQ-025 LOCK SHALL last LOCK_CYCLES cycles, then return to IDLE.
REQ-026 Press events and go SHALL be dropped, not queued, in ARM, FIRE and LOCK.
REQ-027 Latency SHALL be: reboot rises HOLD_CYCLES+1 cycles after the cycle go is sampled.
REQ-028 reboot SHALL be driven directly from a register.

Reset
REQ-029 Asserting reset SHALL immediately force: FSM=IDLE, spi_addr=0, reboot=0, busy=0, slot=0, debouncer stable level=1 (released), counters=0.
REQ-030 Reset mid-ARM or mid-FIRE SHALL cancel the request, with no reboot pulse after release.
REQ-031 The synchronizer flops SHALL reset to 1.

Structure
REQ-032 Package boot_request_pkg SHALL hold the FSM state typedef, the default parameter constants and the 24-bit address width.
REQ-033 The synchronizer+debouncer SHALL be a sub-module named debounce, parameterized by DEBOUNCE_CYCLES, outputting the stable level and the press pulse.

Verification (DEBOUNCE_CYCLES=8, HOLD_CYCLES=4, LOCK_CYCLES=6, SLOT_SHIFT=19)
REQ-034 Write sel_d=3, then pulse go -> slot=3; spi_addr=0x180000 from ARM entry; reboot high for 1 cycle exactly 5 cycles after go; busy high for 11 cycles.
REQ-035 Button low for 5 cycles with glitches, then low for 20 cycles -> only one press event; spi_addr=0x000000; a single reboot pulse.
REQ-036 Press event and go in the same cycle with slot=5 -> spi_addr=0x000000.
REQ-037 go during ARM; sel_we with sel_d=9 during LOCK -> no second pulse; slot unchanged; after IDLE, go -> spi_addr=slot<<19.
REQ-038 Assert reset 2 cycles into ARM -> outputs zero immediately; no reboot pulse within 20 cycles after release.
REQ-039 sel_d=15 with go -> spi_addr=0x780000.
